microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Parametrised next-generation MIC-1 control-store sequencer. It computes and registers MPC from the MIR sequencing fields (next address, JMPC, JAMN, JAMZ), the N/Z flags and MBR.
- Beyond the fixed 9-bit/8-bit original, it adds:
  - configurable address and MBR widths;
  - a microsubroutine call/return stack;
  - a stall (hold) input;
  - sticky stack-error reporting.
- Sits between the control store and the datapath. MPC addresses the control store; MIR fields come back from it.

Parameters:
- ADDR_W, 9: MPC / next_addr width.
- MBR_W, 8: MBR width. Must be < ADDR_W.
- STACK_DEPTH, 4: return-stack entries, >= 1.
- RESET_ADDR, 0: MPC value on reset and on stack underflow.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- next_addr  in  ADDR_W  MIR NEXT_ADDRESS field.
- jmpc  in  1  MIR JMPC bit.
- jamn  in  1  MIR JAMN bit.
- jamz  in  1  MIR JAMZ bit.
- call  in  1  push return address, jump to call_addr.
- ret  in  1  pop stack into MPC.
- call_addr  in  ADDR_W  subroutine entry address.
- N  in  1  ALU negative flag, registered by datapath.
- Z  in  1  ALU zero flag, registered by datapath.
- MBR  in  MBR_W  memory byte register.
- stall  in  1  hold MPC and stack this cycle.
- MPC  out  ADDR_W  micro program counter, registered.
- stack_empty  out  1  no valid stack entries.
- stack_full  out  1  STACK_DEPTH valid entries.
- stack_err  out  1  sticky overflow/underflow/conflict flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - MPC=RESET_ADDR; stack pointer=0; stack_empty=1, stack_full=0, stack_err=0.
  - Stack contents are don't-care.
  - Reset asserted mid-call/ret discards that operation. Release is synchronous to the next rising edge.
- Sequential target T (combinational):
  - hi = next_addr[ADDR_W-1] | (jamn & N) | (jamz & Z).
  - lo = next_addr[ADDR_W-2:0]. If jmpc, OR zero-extended MBR into lo bits [MBR_W-1:0].
  - T = {hi, lo}. With jmpc and jam bits both set, both apply.
- Per rising edge, with rst=1, in priority order:
  1. stall=1: MPC, stack and flags unchanged. call/ret are ignored; no error is raised.
  2. ret=1, stack non-empty: MPC <= top entry, pop. If call is also set, stack_err <= 1 and call is ignored.
  3. ret=1, stack empty: MPC <= RESET_ADDR, stack_err <= 1, pointer stays 0.
  4. call=1, stack not full: push T, MPC <= call_addr.
  5. call=1, stack full: MPC <= call_addr, push dropped (contents unchanged), stack_err <= 1.
  6. Otherwise: MPC <= T.
- Latency:
  - MPC reflects inputs sampled at edge k after edge k; one-cycle latency, no combinational path from inputs to MPC.
  - stack_empty/stack_full are registered and valid the same cycle as the new MPC.
- stack_err is sticky; it clears only on reset.
- Stack is LIFO:
  - Pointer range 0..STACK_DEPTH, no wrap-around.
  - Push and pop never happen in the same cycle.
- Widths: MBR never reaches bit ADDR_W-1. next_addr bits above MBR_W are never altered by jmpc.

Test Plan:
- Reset, defaults: hold rst=0, then release; next_addr=0, no jumps -> MPC=0, stack_empty=1, stack_err=0. Assert rst=0 asynchronously mid-cycle with MPC=0x0A5 -> MPC=0 immediately, without waiting for a clock edge.
- Branches: next_addr=0x012 with jamz=1, Z=1 -> MPC=0x112. Same with Z=0 -> 0x012. jamn=1, N=1, next_addr=0x100 -> 0x100, since hi is already set.
- JMPC dispatch: next_addr=0x000, jmpc=1, MBR=0x60 -> MPC=0x060. next_addr=0x100, MBR=0xFF -> MPC=0x1FF.
- Call/return: call=1, call_addr=0x150, next_addr=0x020 -> MPC=0x150, stack_empty=0. A later ret=1 -> MPC=0x020, stack_empty=1.
- Overflow/underflow, STACK_DEPTH=4:
  - Five nested calls -> stack_full=1 after the 4th call; the 5th still jumps, stack_err=1.
  - Then four rets return in reverse order.
  - A 5th ret -> MPC=RESET_ADDR, stack_err stays 1.
- Stall and conflict:
  - stall=1 with call=1 for 3 cycles -> MPC and stack unchanged, stack_err=0.
  - With one entry pushed, call=ret=1 -> pop taken, stack_err=1.

Source files
------------

// File: rtl/microsequencer.sv
// MIC-1 style control-store sequencer: registered MPC from MIR sequencing
// fields, N/Z flags and MBR, with a microsubroutine return stack and stall.
module microsequencer #(
    parameter int                ADDR_W      = 9,
    parameter int                MBR_W       = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              jmpc,
    input  logic              jamn,
    input  logic              jamz,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] call_addr,
    input  logic              N,
    input  logic              Z,
    input  logic [MBR_W-1:0]  MBR,
    input  logic              stall,
    output logic [ADDR_W-1:0] MPC,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    localparam int PTR_W     = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int MEM_DEPTH = 1 << IDX_W;

    logic [ADDR_W-1:0] mpc_reg, mpc_next;
    logic [PTR_W-1:0]  sp_reg, sp_next;
    logic              err_reg, err_next;
    logic              empty_reg, full_reg;
    logic              push;
    logic [ADDR_W-1:0] stack_mem [MEM_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [ADDR_W-1:0] top_entry;

    logic              target_hi;
    logic [ADDR_W-2:0] mbr_ext;
    logic [ADDR_W-2:0] target_lo;
    logic [ADDR_W-1:0] target;

    // MBR is zero-extended into the low field only, so it never reaches the jam bit.
    always_comb begin
        mbr_ext              = '0;
        mbr_ext[MBR_W-1:0]   = MBR;
        target_hi            = next_addr[ADDR_W-1] | (jamn & N) | (jamz & Z);
        target_lo            = next_addr[ADDR_W-2:0] | (jmpc ? mbr_ext : '0);
        target               = {target_hi, target_lo};
    end

    assign top_ptr   = sp_reg - PTR_W'(1);
    assign top_entry = stack_mem[top_ptr[IDX_W-1:0]];

    always_comb begin
        mpc_next = mpc_reg;
        sp_next  = sp_reg;
        err_next = err_reg;
        push     = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (!empty_reg) begin
                    mpc_next = top_entry;
                    sp_next  = sp_reg - PTR_W'(1);
                    if (call)
                        err_next = 1'b1;
                end else begin
                    mpc_next = RESET_ADDR;
                    err_next = 1'b1;
                end
            end else if (call) begin
                mpc_next = call_addr;
                if (!full_reg) begin
                    push    = 1'b1;
                    sp_next = sp_reg + PTR_W'(1);
                end else begin
                    err_next = 1'b1;
                end
            end else begin
                mpc_next = target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mpc_reg   <= RESET_ADDR;
            sp_reg    <= '0;
            err_reg   <= 1'b0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
        end else begin
            mpc_reg   <= mpc_next;
            sp_reg    <= sp_next;
            err_reg   <= err_next;
            empty_reg <= (sp_next == '0);
            full_reg  <= (sp_next == PTR_W'(STACK_DEPTH));
        end
    end

    // Stack storage carries no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push && rst)
            stack_mem[sp_reg[IDX_W-1:0]] <= target;
    end

    assign MPC         = mpc_reg;
    assign stack_empty = empty_reg;
    assign stack_full  = full_reg;
    assign stack_err   = err_reg;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: table of branch/dispatch vectors plus
// hand-written call/return, overflow, stall and reset sequences.
module tb_microsequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] next_addr;
    logic       jmpc, jamn, jamz, call, ret, N, Z, stall;
    logic [8:0] call_addr;
    logic [7:0] MBR;
    logic [8:0] MPC;
    logic       stack_empty, stack_full, stack_err;

    int compared   = 0;
    int mismatched = 0;

    microsequencer #(.ADDR_W(9), .MBR_W(8), .STACK_DEPTH(4), .RESET_ADDR(9'h000)) dut (
        .clk(clk), .rst(rst), .next_addr(next_addr), .jmpc(jmpc), .jamn(jamn),
        .jamz(jamz), .call(call), .ret(ret), .call_addr(call_addr), .N(N), .Z(Z),
        .MBR(MBR), .stall(stall), .MPC(MPC), .stack_empty(stack_empty),
        .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] na;
        logic       jmpc;
        logic       jamn;
        logic       jamz;
        logic       n;
        logic       z;
        logic [7:0] mbr;
        logic [8:0] exp_mpc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic idle_inputs();
        next_addr = '0; jmpc = 0; jamn = 0; jamz = 0; call = 0; ret = 0;
        call_addr = '0; N = 0; Z = 0; MBR = '0; stall = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [8:0] na, input logic [8:0] ca);
        idle_inputs();
        next_addr = na; call = 1; call_addr = ca;
        step();
    endtask

    task automatic do_ret();
        idle_inputs();
        ret = 1;
        step();
    endtask

    task automatic pulse_reset();
        #2 rst = 0;
        #1;
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        vecs[0] = '{9'h012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 9'h112};
        vecs[1] = '{9'h012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9'h012};
        vecs[2] = '{9'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 9'h100};
        vecs[3] = '{9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h60, 9'h060};
        vecs[4] = '{9'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 9'h1FF};
        vecs[5] = '{9'h012, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h21, 9'h133};
        vecs[6] = '{9'h012, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 9'h012};
        vecs[7] = '{9'h0F0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 9'h1FF};
        vecs[8] = '{9'h0A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 9'h0A5};

        idle_inputs();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mpc", 32'(MPC), 32'h000);
        check("reset_empty", 32'(stack_empty), 32'd1);
        check("reset_full", 32'(stack_full), 32'd0);
        check("reset_err", 32'(stack_err), 32'd0);
        @(negedge clk);
        rst = 1;
        step();
        check("idle_mpc", 32'(MPC), 32'h000);

        // Combinational target table
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            next_addr = vecs[i].na; jmpc = vecs[i].jmpc; jamn = vecs[i].jamn;
            jamz = vecs[i].jamz; N = vecs[i].n; Z = vecs[i].z; MBR = vecs[i].mbr;
            step();
            check($sformatf("vec%0d_mpc", i), 32'(MPC), 32'(vecs[i].exp_mpc));
            check($sformatf("vec%0d_empty", i), 32'(stack_empty), 32'd1);
        end

        // Asynchronous reset mid-cycle with MPC=0x0A5
        check("pre_async_mpc", 32'(MPC), 32'h0A5);
        #2 rst = 0;
        #1;
        check("async_reset_mpc", 32'(MPC), 32'h000);
        @(negedge clk);
        rst = 1;

        // Call / return
        do_call(9'h020, 9'h150);
        check("call_mpc", 32'(MPC), 32'h150);
        check("call_empty", 32'(stack_empty), 32'd0);
        do_ret();
        check("ret_mpc", 32'(MPC), 32'h020);
        check("ret_empty", 32'(stack_empty), 32'd1);
        check("ret_err", 32'(stack_err), 32'd0);

        // Overflow: five nested calls
        for (int i = 0; i < 5; i++) begin
            do_call(9'h010 + 9'(i), 9'h100 + 9'(i));
            check($sformatf("ncall%0d_mpc", i), 32'(MPC), 32'h100 + 32'(i));
            check($sformatf("ncall%0d_full", i), 32'(stack_full), (i >= 3) ? 32'd1 : 32'd0);
            check($sformatf("ncall%0d_err", i), 32'(stack_err), (i == 4) ? 32'd1 : 32'd0);
        end
        for (int i = 3; i >= 0; i--) begin
            do_ret();
            check($sformatf("nret%0d_mpc", i), 32'(MPC), 32'h010 + 32'(i));
            check($sformatf("nret%0d_empty", i), 32'(stack_empty), (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("nret%0d_full", i), 32'(stack_full), 32'd0);
        end
        // Underflow
        idle_inputs();
        next_addr = 9'h077;
        step();
        check("pre_uflow_mpc", 32'(MPC), 32'h077);
        do_ret();
        check("uflow_mpc", 32'(MPC), 32'h000);
        check("uflow_err", 32'(stack_err), 32'd1);
        check("uflow_empty", 32'(stack_empty), 32'd1);
        idle_inputs();
        step();
        check("err_sticky", 32'(stack_err), 32'd1);

        pulse_reset();
        check("err_cleared", 32'(stack_err), 32'd0);

        // Stall with call held for three cycles
        idle_inputs();
        next_addr = 9'h033;
        step();
        check("pre_stall_mpc", 32'(MPC), 32'h033);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            stall = 1; call = 1; call_addr = 9'h1AA; next_addr = 9'h055;
            step();
            check($sformatf("stall%0d_mpc", i), 32'(MPC), 32'h033);
            check($sformatf("stall%0d_empty", i), 32'(stack_empty), 32'd1);
            check($sformatf("stall%0d_err", i), 32'(stack_err), 32'd0);
        end

        // Call/ret conflict with one entry pushed
        do_call(9'h044, 9'h077);
        check("conf_call_mpc", 32'(MPC), 32'h077);
        idle_inputs();
        stall = 1; ret = 1;
        step();
        check("stall_ret_mpc", 32'(MPC), 32'h077);
        check("stall_ret_empty", 32'(stack_empty), 32'd0);
        idle_inputs();
        call = 1; ret = 1; call_addr = 9'h0EE; next_addr = 9'h011;
        step();
        check("conf_mpc", 32'(MPC), 32'h044);
        check("conf_err", 32'(stack_err), 32'd1);
        check("conf_empty", 32'(stack_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
